// File: rtl/core_pkg.sv
// core_pkg: definitions shared by the pipeline hazard controller.
//   FWD_*           forwarding-mux select encodings for ForwardAE/ForwardBE
//   REG_PC          architectural index of the PC (R15); never forwarded
//   long_state_e    state of the long-multiply sequencer
//   fwd_sel()       forwarding priority for one Execute source operand
package core_pkg;

  localparam logic [1:0] FWD_REG = 2'b00;  // register file value
  localparam logic [1:0] FWD_WB  = 2'b01;  // ResultW
  localparam logic [1:0] FWD_MEM = 2'b10;  // ALUResultM

  localparam logic [3:0] REG_PC = 4'd15;

  typedef enum logic {
    LONG_IDLE = 1'b0,
    LONG_BUSY = 1'b1
  } long_state_e;

  // Memory stage is younger than writeback, so its value wins.
  function automatic logic [1:0] fwd_sel(
    input logic [3:0] ra,
    input logic       reg_write_m,
    input logic [3:0] wa3_m,
    input logic       reg_write_w,
    input logic [3:0] wa3_w
  );
    logic [1:0] sel;
    sel = FWD_REG;
    if (ra != REG_PC) begin
      if (reg_write_m && (wa3_m == ra)) begin
        sel = FWD_MEM;
      end else if (reg_write_w && (wa3_w == ra)) begin
        sel = FWD_WB;
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/long_mul_seq.sv
// long_mul_seq: sequences a multi-cycle long multiply held in Execute.
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   long_start_i    condition-passed long multiply present in Execute
//   busy_o          E must stay frozen this cycle (combinational, so the
//                   very first multiply cycle already stalls)
//   long_last_o     final multiply cycle; the E result is valid
//   state_o         current sequencer state (debug visibility)
//
// Start/last protocol: long_start_i acts as a level "valid" that the frozen
// Execute stage keeps asserting while the op is held there; long_last_o is
// the one-cycle "done" after which E advances. long_start_i seen while BUSY
// is the same op repeating and is ignored. The op occupies E for exactly
// MUL_CYCLES cycles: one IDLE cycle that loads the counter, then MUL_CYCLES-1
// BUSY cycles counting down to zero. MUL_CYCLES=1 never leaves IDLE.
module long_mul_seq
  import core_pkg::*;
#(
  parameter int MUL_CYCLES = 3
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        long_start_i,
  output logic        busy_o,
  output logic        long_last_o,
  output long_state_e state_o
);

  localparam bit         MultiCycle = (MUL_CYCLES > 1);
  localparam int         LoadVal    = (MUL_CYCLES > 1) ? (MUL_CYCLES - 2) : 0;
  localparam logic [3:0] CntLoad    = 4'(LoadVal);

  long_state_e state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= LONG_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    busy_o      = 1'b0;
    long_last_o = 1'b0;
    case (state_q)
      LONG_IDLE: begin
        if (long_start_i && MultiCycle) begin
          busy_o  = 1'b1;
          cnt_d   = CntLoad;
          state_d = LONG_BUSY;
        end
      end
      LONG_BUSY: begin
        if (cnt_q == 4'd0) begin
          long_last_o = 1'b1;
          state_d     = LONG_IDLE;
        end else begin
          busy_o = 1'b1;
          cnt_d  = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = LONG_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign state_o = state_q;

endmodule

// File: rtl/hazard_unit.sv
// hazard_unit: pipeline hazard controller for the 5-stage F/D/E/M/W core.
//   clk, reset                   clock, asynchronous active-low reset
//   RA1D/RA2D, RA1E/RA2E         source registers in Decode / Execute
//   WA3E/WA3M/WA3W               destination registers in E/M/W
//   RegWriteE/M/W, MemToRegE     write enables per stage, load in Execute
//   PCSrcD/E/M/W, BranchTakenE   PC-writing instructions, taken branch
//   LongStartE                   long multiply present in Execute
//   ForwardAE/ForwardBE          forwarding selects (see core_pkg FWD_*)
//   StallF/D/E, FlushD/E/M       pipeline register hold / bubble controls
//   LongBusyE, LongLastE         multiplier occupied / final cycle
// Optional macro HAZARD_PERF_CNT_EN adds parameter CNT_W and saturating
// counters StallCnt, FlushCnt, LongCnt.
module hazard_unit
  import core_pkg::*;
#(
  parameter int MUL_CYCLES = 3
`ifdef HAZARD_PERF_CNT_EN
  , parameter int CNT_W = 32
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] RA1D,
  input  logic [3:0] RA2D,
  input  logic [3:0] RA1E,
  input  logic [3:0] RA2E,
  input  logic [3:0] WA3E,
  input  logic [3:0] WA3M,
  input  logic [3:0] WA3W,
  input  logic       RegWriteE,
  input  logic       RegWriteM,
  input  logic       RegWriteW,
  input  logic       MemToRegE,
  input  logic       PCSrcD,
  input  logic       PCSrcE,
  input  logic       PCSrcM,
  input  logic       PCSrcW,
  input  logic       BranchTakenE,
  input  logic       LongStartE,
  output logic [1:0] ForwardAE,
  output logic [1:0] ForwardBE,
  output logic       StallF,
  output logic       StallD,
  output logic       StallE,
  output logic       FlushD,
  output logic       FlushE,
  output logic       FlushM,
  output logic       LongBusyE,
  output logic       LongLastE
`ifdef HAZARD_PERF_CNT_EN
  , output logic [CNT_W-1:0] StallCnt
  , output logic [CNT_W-1:0] FlushCnt
  , output logic [CNT_W-1:0] LongCnt
`endif
);

  logic        ldr_stall;
  logic        pc_pend;
  logic        busy;
  long_state_e long_state;

  long_mul_seq #(
    .MUL_CYCLES (MUL_CYCLES)
  ) u_long_mul_seq (
    .clk_i        (clk),
    .rst_ni       (reset),
    .long_start_i (LongStartE),
    .busy_o       (busy),
    .long_last_o  (LongLastE),
    .state_o      (long_state)
  );

  // Occupied covers the loading cycle plus every BUSY cycle, including the
  // final one in which E is no longer frozen but still holds the multiply.
  assign LongBusyE = busy | (long_state == LONG_BUSY);

  always_comb begin
    ForwardAE = fwd_sel(RA1E, RegWriteM, WA3M, RegWriteW, WA3W);
    ForwardBE = fwd_sel(RA2E, RegWriteM, WA3M, RegWriteW, WA3W);
  end

  assign ldr_stall = MemToRegE & RegWriteE & ((WA3E == RA1D) | (WA3E == RA2D));
  assign pc_pend   = PCSrcD | PCSrcE | PCSrcM;

  // A frozen E stage must never be bubbled, so busy masks both flushes; the
  // pending load-use stall or branch is taken once the multiply releases E.
  always_comb begin
    StallF = ldr_stall | pc_pend | busy;
    StallD = ldr_stall | busy;
    StallE = busy;
    FlushM = busy;
    FlushD = (pc_pend | PCSrcW | BranchTakenE) & ~busy;
    FlushE = (ldr_stall | BranchTakenE) & ~busy;
  end

`ifdef HAZARD_PERF_CNT_EN
  localparam logic [CNT_W-1:0] CntOne = 1;

  logic             long_evt;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic [CNT_W-1:0] long_cnt_q, long_cnt_d;

  // Single-cycle multiplies never reach BUSY, so count them at start.
  assign long_evt = LongLastE | ((MUL_CYCLES == 1) & LongStartE);

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    long_cnt_d  = long_cnt_q;
    if (StallF && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CntOne;
    if ((FlushD || FlushE) && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CntOne;
    if (long_evt && (long_cnt_q != '1)) long_cnt_d = long_cnt_q + CntOne;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      long_cnt_q  <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      long_cnt_q  <= long_cnt_d;
    end
  end

  assign StallCnt = stall_cnt_q;
  assign FlushCnt = flush_cnt_q;
  assign LongCnt  = long_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Testbench for hazard_unit: one instance with MUL_CYCLES=3 and one with
// MUL_CYCLES=1 share the same stimulus; each output word is compared with a
// bench-computed expectation taken from a scoreboard queue.
module tb_hazard_unit;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic [3:0] RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W;
  logic RegWriteE, RegWriteM, RegWriteW, MemToRegE;
  logic PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE, LongStartE;

  logic [1:0] fa3, fb3, fa1, fb1;
  logic sf3, sd3, se3, fd3, fe3, fm3, lb3, ll3;
  logic sf1, sd1, se1, fd1, fe1, fm1, lb1, ll1;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] sc3, fc3, lc3, sc1, fc1, lc1;
`endif

  hazard_unit #(.MUL_CYCLES(3)) dut3 (
    .clk(clk), .reset(reset),
    .RA1D(RA1D), .RA2D(RA2D), .RA1E(RA1E), .RA2E(RA2E),
    .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemToRegE(MemToRegE),
    .PCSrcD(PCSrcD), .PCSrcE(PCSrcE), .PCSrcM(PCSrcM), .PCSrcW(PCSrcW),
    .BranchTakenE(BranchTakenE), .LongStartE(LongStartE),
    .ForwardAE(fa3), .ForwardBE(fb3),
    .StallF(sf3), .StallD(sd3), .StallE(se3),
    .FlushD(fd3), .FlushE(fe3), .FlushM(fm3),
    .LongBusyE(lb3), .LongLastE(ll3)
`ifdef HAZARD_PERF_CNT_EN
    , .StallCnt(sc3), .FlushCnt(fc3), .LongCnt(lc3)
`endif
  );

  hazard_unit #(.MUL_CYCLES(1)) dut1 (
    .clk(clk), .reset(reset),
    .RA1D(RA1D), .RA2D(RA2D), .RA1E(RA1E), .RA2E(RA2E),
    .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemToRegE(MemToRegE),
    .PCSrcD(PCSrcD), .PCSrcE(PCSrcE), .PCSrcM(PCSrcM), .PCSrcW(PCSrcW),
    .BranchTakenE(BranchTakenE), .LongStartE(LongStartE),
    .ForwardAE(fa1), .ForwardBE(fb1),
    .StallF(sf1), .StallD(sd1), .StallE(se1),
    .FlushD(fd1), .FlushE(fe1), .FlushM(fm1),
    .LongBusyE(lb1), .LongLastE(ll1)
`ifdef HAZARD_PERF_CNT_EN
    , .StallCnt(sc1), .FlushCnt(fc1), .LongCnt(lc1)
`endif
  );

  logic [11:0] act3, act1;
  assign act3 = {fa3, fb3, sf3, sd3, se3, fd3, fe3, fm3, lb3, ll3};
  assign act1 = {fa1, fb1, sf1, sd1, se1, fd1, fe1, fm1, lb1, ll1};

  // ---------------- stimulus records ----------------
  typedef struct packed {
    logic [3:0] ra1d, ra2d, ra1e, ra2e, wa3e, wa3m, wa3w;
    logic rwe, rwm, rww, m2r, pcd, pce, pcm, pcw, bt, ls;
  } in_t;

  typedef struct {
    string       name;
    in_t         i;
    logic [11:0] e;
  } vec_t;

  vec_t        tab[$];
  logic [23:0] exp_q[$];   // {expected mc1, expected mc3}
  string       name_q[$];
  int          errors = 0;
  int          checks = 0;
  int          exp_sc3 = 0, exp_fc3 = 0, exp_lc3 = 0;
  int          exp_sc1 = 0, exp_fc1 = 0, exp_lc1 = 0;

  localparam logic [11:0] Z = 12'h000;

  // Word layout: {FwdA, FwdB, StallF, StallD, StallE, FlushD, FlushE, FlushM, LongBusy, LongLast}
  function automatic logic [11:0] pk(input logic [1:0] fa, input logic [1:0] fb,
                                     input logic sf, input logic sd, input logic se,
                                     input logic fd, input logic fe, input logic fm,
                                     input logic lb, input logic ll);
    return {fa, fb, sf, sd, se, fd, fe, fm, lb, ll};
  endfunction

  function automatic logic [1:0] mfwd(input logic [3:0] ra, input logic rwm, input logic [3:0] wam,
                                      input logic rww, input logic [3:0] waw);
    if (ra == 4'd15) return 2'b00;
    if (rwm && wam == ra) return 2'b10;
    if (rww && waw == ra) return 2'b01;
    return 2'b00;
  endfunction

  // ---------------- driver ----------------
  task automatic drive(input in_t v);
    RA1D = v.ra1d; RA2D = v.ra2d; RA1E = v.ra1e; RA2E = v.ra2e;
    WA3E = v.wa3e; WA3M = v.wa3m; WA3W = v.wa3w;
    RegWriteE = v.rwe; RegWriteM = v.rwm; RegWriteW = v.rww; MemToRegE = v.m2r;
    PCSrcD = v.pcd; PCSrcE = v.pce; PCSrcM = v.pcm; PCSrcW = v.pcw;
    BranchTakenE = v.bt; LongStartE = v.ls;
  endtask

  // ---------------- scoreboard ----------------
  task automatic check_val(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic sample();
    logic [23:0] e;
    string nm;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_empty actual=0 required=1");
      return;
    end
    e  = exp_q.pop_front();
    nm = name_q.pop_front();
    check_val({nm, "/mc3"}, {20'd0, act3}, {20'd0, e[11:0]});
    check_val({nm, "/mc1"}, {20'd0, act1}, {20'd0, e[23:12]});
    // counters see these inputs at the coming edge
    if (reset) begin
      exp_sc3 += int'(e[7]);  exp_fc3 += int'(e[4] | e[3]);  exp_lc3 += int'(e[0]);
      exp_sc1 += int'(e[19]); exp_fc1 += int'(e[16] | e[15]); exp_lc1 += int'(LongStartE);
    end
  endtask

  task automatic check_cnts(input string nm);
`ifdef HAZARD_PERF_CNT_EN
    check_val({nm, "/StallCnt3"}, sc3, exp_sc3);
    check_val({nm, "/FlushCnt3"}, fc3, exp_fc3);
    check_val({nm, "/LongCnt3"},  lc3, exp_lc3);
    check_val({nm, "/StallCnt1"}, sc1, exp_sc1);
    check_val({nm, "/FlushCnt1"}, fc1, exp_fc1);
    check_val({nm, "/LongCnt1"},  lc1, exp_lc1);
`endif
  endtask

  task automatic step(input string nm, input in_t v, input logic [11:0] e3, input logic [11:0] e1);
    @(posedge clk);
    #1;
    check_cnts({nm, "_pre"});
    drive(v);
    exp_q.push_back({e1, e3});
    name_q.push_back(nm);
    @(negedge clk);
    sample();
  endtask

  task automatic add(input string nm, input in_t v, input logic [11:0] e);
    vec_t r;
    r.name = nm; r.i = v; r.e = e;
    tab.push_back(r);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- test ----------------
  initial begin
    in_t b;
    logic [11:0] busy_w, last_w, ldr_w, pcp_w;
    busy_w = pk(2'b00, 2'b00, 1, 1, 1, 0, 0, 1, 1, 0);
    last_w = pk(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 1, 1);
    ldr_w  = pk(2'b00, 2'b00, 1, 1, 0, 0, 1, 0, 0, 0);
    pcp_w  = pk(2'b00, 2'b00, 1, 0, 0, 1, 0, 0, 0, 0);

    drive('0);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    exp_q.push_back({Z, Z});
    name_q.push_back("reset_state");
    sample();
    check_cnts("reset_state");
    #1 reset = 1'b1;

    // single-cycle vectors
    b = '0; b.rwm = 1; b.wa3m = 3; b.rww = 1; b.wa3w = 3; b.ra1e = 3; b.ra2e = 1;
    add("fwd_a_mem", b, pk(2'b10, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0));
    b.rwm = 0;
    add("fwd_a_wb", b, pk(2'b01, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0));
    b = '0; b.rwm = 1; b.wa3m = 15; b.rww = 1; b.wa3w = 15; b.ra1e = 15; b.ra2e = 15;
    add("fwd_r15", b, Z);
    b = '0; b.rwm = 1; b.wa3m = 5; b.ra2e = 5; b.ra1e = 2;
    add("fwd_b_mem", b, pk(2'b00, 2'b10, 0, 0, 0, 0, 0, 0, 0, 0));
    b = '0; b.rww = 1; b.wa3w = 4; b.ra1e = 4; b.rwm = 1; b.wa3m = 6; b.ra2e = 6;
    add("fwd_mixed", b, pk(2'b01, 2'b10, 0, 0, 0, 0, 0, 0, 0, 0));
    b = '0; b.m2r = 1; b.rwe = 1; b.wa3e = 2; b.ra2d = 2; b.ra1d = 9;
    add("ldr_ra2", b, ldr_w);
    b = '0; b.m2r = 1; b.rwe = 1; b.wa3e = 7; b.ra1d = 7; b.ra2d = 1;
    add("ldr_ra1", b, ldr_w);
    b.rwe = 0;
    add("ldr_nowrite", b, Z);
    b = '0; b.m2r = 1; b.rwe = 1; b.wa3e = 8; b.ra1d = 1; b.ra2d = 2;
    add("ldr_nomatch", b, Z);
    b = '0; b.bt = 1;
    add("branch", b, pk(2'b00, 2'b00, 0, 0, 0, 1, 1, 0, 0, 0));
    b = '0; b.pce = 1;
    add("pcsrc_e", b, pcp_w);
    b = '0; b.pcw = 1;
    add("pcsrc_w", b, pk(2'b00, 2'b00, 0, 0, 0, 1, 0, 0, 0, 0));
    b = '0; b.bt = 1; b.m2r = 1; b.rwe = 1; b.wa3e = 4; b.ra1d = 4;
    add("ldr_branch", b, pk(2'b00, 2'b00, 1, 1, 0, 1, 1, 0, 0, 0));

    foreach (tab[k]) step(tab[k].name, tab[k].i, tab[k].e, tab[k].e);

    // randomised forwarding against the priority model
    for (int n = 0; n < 30; n++) begin
      logic [1:0] ea, eb;
      b = '0;
      b.ra1e = ($urandom_range(0, 4) == 4) ? 4'd15 : 4'($urandom_range(0, 3));
      b.ra2e = ($urandom_range(0, 4) == 4) ? 4'd15 : 4'($urandom_range(0, 3));
      b.wa3m = ($urandom_range(0, 4) == 4) ? 4'd15 : 4'($urandom_range(0, 3));
      b.wa3w = ($urandom_range(0, 4) == 4) ? 4'd15 : 4'($urandom_range(0, 3));
      b.rwm  = 1'($urandom_range(0, 1));
      b.rww  = 1'($urandom_range(0, 1));
      ea = mfwd(b.ra1e, b.rwm, b.wa3m, b.rww, b.wa3w);
      eb = mfwd(b.ra2e, b.rwm, b.wa3m, b.rww, b.wa3w);
      step($sformatf("fwd_rand%0d", n), b, pk(ea, eb, 0, 0, 0, 0, 0, 0, 0, 0),
           pk(ea, eb, 0, 0, 0, 0, 0, 0, 0, 0));
    end

    // load-use: one stall cycle, then the bubble clears it
    b = '0; b.m2r = 1; b.rwe = 1; b.wa3e = 2; b.ra2d = 2;
    step("lu_c0", b, ldr_w, ldr_w);
    step("lu_c1", '0, Z, Z);

    // PC write walking D -> E -> M -> W
    b = '0; b.pcd = 1; step("pc_d", b, pcp_w, pcp_w);
    b = '0; b.pce = 1; step("pc_e", b, pcp_w, pcp_w);
    b = '0; b.pcm = 1; step("pc_m", b, pcp_w, pcp_w);
    b = '0; b.pcw = 1;
    step("pc_w", b, pk(2'b00, 2'b00, 0, 0, 0, 1, 0, 0, 0, 0), pk(2'b00, 2'b00, 0, 0, 0, 1, 0, 0, 0, 0));
    step("pc_done", '0, Z, Z);

    // long multiply, op held in E until its last cycle
    b = '0; b.ls = 1;
    step("lm_c0", b, busy_w, Z);
    step("lm_c1", b, busy_w, Z);
    step("lm_c2", b, last_w, Z);
    step("lm_c3", '0, Z, Z);

    // long multiply with a load-use hazard waiting in D
    b = '0; b.ls = 1; b.m2r = 1; b.rwe = 1; b.wa3e = 2; b.ra1d = 2;
    step("lml_c0", b, busy_w, ldr_w);
    step("lml_c1", b, busy_w, ldr_w);
    step("lml_c2", b, pk(2'b00, 2'b00, 1, 1, 0, 0, 1, 0, 1, 1), ldr_w);
    step("lml_c3", '0, Z, Z);

    // long multiply with a taken branch and a PC write pending
    b = '0; b.ls = 1; b.bt = 1; b.pcd = 1;
    step("lmb_c0", b, busy_w, pk(2'b00, 2'b00, 1, 0, 0, 1, 1, 0, 0, 0));
    step("lmb_c1", b, busy_w, pk(2'b00, 2'b00, 1, 0, 0, 1, 1, 0, 0, 0));
    step("lmb_c2", b, pk(2'b00, 2'b00, 1, 0, 0, 1, 1, 0, 1, 1), pk(2'b00, 2'b00, 1, 0, 0, 1, 1, 0, 0, 0));
    step("lmb_c3", '0, Z, Z);

    // reset during the first BUSY cycle aborts the multiply
    b = '0; b.ls = 1;
    step("rst_c0", b, busy_w, Z);
    step("rst_c1", b, busy_w, Z);
    drive('0);
    reset = 1'b0;
    #1;
    exp_q.push_back({Z, Z});
    name_q.push_back("rst_mid");
    sample();
    exp_sc3 = 0; exp_fc3 = 0; exp_lc3 = 0;
    exp_sc1 = 0; exp_fc1 = 0; exp_lc1 = 0;
    check_cnts("rst_mid");
    step("rst_hold", '0, Z, Z);
    reset = 1'b1;
    step("rst_after0", '0, Z, Z);
    step("rst_after1", '0, Z, Z);

    // sequencer restarts cleanly after the abort
    b = '0; b.ls = 1;
    step("re_c0", b, busy_w, Z);
    step("re_c1", b, busy_w, Z);
    step("re_c2", b, last_w, Z);
    step("re_c3", '0, Z, Z);
    step("re_end", '0, Z, Z);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hazard_unit.md
Name: hazard_unit

Overview:
- Pipeline hazard controller for the 5-stage core (F/D/E/M/W).
- Generates register forwarding selects, load-use stalls, branch/PC-write flushes, and sequences multi-cycle long multiplies (UMULL/SMULL, LongE) by freezing F/D/E and bubbling M until the multiplier finishes.
- Sits beside the controller; drives its StallD/FlushD/FlushE inputs and the datapath forwarding muxes.

Parameters:
- MUL_CYCLES, 3, Execute-stage cycles a long multiply occupies (legal range 1..15).
- CNT_W, 32, width of the performance counters (feature-gated).

Ports:
- clk  in  1  core clock
- reset  in  1  asynchronous, active-low reset
- RA1D, RA2D  in  4  source registers of the instruction in Decode
- RA1E, RA2E  in  4  source registers of the instruction in Execute
- WA3E, WA3M, WA3W  in  4  destination register in E/M/W
- RegWriteE, RegWriteM, RegWriteW  in  1  register-write enables per stage, already condition-gated in M/W
- MemToRegE  in  1  load in Execute
- PCSrcD, PCSrcE, PCSrcM, PCSrcW  in  1  PC-write instruction in each stage
- BranchTakenE  in  1  branch resolved taken in Execute
- LongStartE  in  1  condition-passed long multiply present in Execute
- ForwardAE, ForwardBE  out  2  00 regfile, 01 ResultW, 10 ALUResultM
- StallF, StallD, StallE  out  1  hold the pipeline register feeding that stage
- FlushD, FlushE, FlushM  out  1  clear the pipeline register feeding that stage (bubble)
- LongBusyE  out  1  multiplier occupied; E is frozen
- LongLastE  out  1  final multiplier cycle; E result is valid

Behaviour:
- Forwarding is combinational.
- ForwardAE = 10 if RegWriteM & WA3M==RA1E & RA1E!=15.
- Otherwise ForwardAE = 01 if RegWriteW & WA3W==RA1E & RA1E!=15.
- Otherwise ForwardAE = 00.
- ForwardBE uses RA2E with the same rules. M has priority over W. R15 is never forwarded.
- ldrStall = MemToRegE & RegWriteE & (WA3E==RA1D | WA3E==RA2D).
- pcPend = PCSrcD | PCSrcE | PCSrcM.
- Long-multiply FSM, 2 states:
  - IDLE: if LongStartE and MUL_CYCLES>1, load cnt=MUL_CYCLES-2 and go to BUSY. With MUL_CYCLES=1 the FSM never leaves IDLE.
  - BUSY: LongBusyE=1. If cnt==0, assert LongLastE and return to IDLE next edge; otherwise cnt decrements.
- busy = (state==IDLE & LongStartE & MUL_CYCLES>1) | (state==BUSY & !LongLastE). This is combinational, so the first multiply cycle already stalls.
- StallF = ldrStall | pcPend | busy
- StallD = ldrStall | busy
- StallE = busy
- FlushM = busy (bubble into M each frozen cycle)
- FlushD = (pcPend | PCSrcW | BranchTakenE) & !busy
- FlushE = (ldrStall | BranchTakenE) & !busy. Busy overrides: E is never flushed while holding a multiply.
- Stall and flush on the same register: flush wins, except as suppressed by busy above.
- Total E occupancy of a long multiply is exactly MUL_CYCLES cycles. Younger instructions resume the cycle after LongLastE.
- reset low (async): state=IDLE, cnt=0. All outputs follow from the combinational rules with LongBusyE=LongLastE=0.
- Reset mid-multiply aborts it; no spurious LongLastE is produced.
- LongStartE while BUSY is ignored, since E is frozen and the signal repeats the same op.

Optional Feature:
- Macro HAZARD_PERF_CNT_EN.
- With the macro: adds outputs StallCnt, FlushCnt, LongCnt (CNT_W each), all reset to 0.
  - StallCnt increments every cycle StallF=1.
  - FlushCnt increments every cycle FlushD|FlushE=1.
  - LongCnt increments per LongLastE, or per LongStartE when MUL_CYCLES=1.
  - All counters saturate at all-ones.
- Without the macro: the ports and logic are absent; remaining behaviour is identical.

Decomposition:
- Shared package (core_pkg) holds:
  - FWD_REG=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10
  - REG_PC=4'd15
  - long-FSM state enum
- Natural sub-module: long_mul_seq (FSM, counter, busy/LongLastE). The top level keeps forwarding and stall/flush logic.

Test Plan:
- Forwarding: RegWriteM=1, WA3M=3, RegWriteW=1, WA3W=3, RA1E=3 -> ForwardAE=10. With RegWriteM=0 -> 01. With RA1E=15 -> 00.
- Load-use: MemToRegE=1, RegWriteE=1, WA3E=2, RA2D=2 -> StallF=StallD=FlushE=1 for one cycle, then all 0.
- Branch: BranchTakenE=1 -> FlushD=FlushE=1, StallF=0. PCSrcD=1 -> StallF=1, FlushD=1 for 3 cycles as it moves D->E->M, then PCSrcW releases.
- Long multiply, MUL_CYCLES=3: LongStartE pulse -> StallF/D/E and FlushM high for 2 cycles, LongLastE on the 3rd cycle, then pipeline resumes. Repeat with MUL_CYCLES=1 -> no stall.
- Long op with concurrent ldrStall on D -> FlushE stays 0 while busy. After LongLastE, the load-use stall is taken.
- Reset asserted (low) during BUSY cycle 1 -> LongBusyE=0 immediately, no LongLastE. With HAZARD_PERF_CNT_EN, counters read 0.
